// File: rtl/drive_pkg.sv
// Shared enums and IR remote codes for the drive mode controller.
package drive_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_CAM  = 2'd1,
      MODE_IR   = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      CAM_PAUSE  = 2'd0,
      CAM_SEARCH = 2'd1,
      CAM_FOLLOW = 2'd2,
      CAM_LOST   = 2'd3
   } cam_e;

   typedef enum logic [1:0] {
      DIR_STOP  = 2'd0,
      DIR_LEFT  = 2'd1,
      DIR_RIGHT = 2'd2,
      DIR_FWD   = 2'd3
   } dir_e;

   localparam logic [7:0] CMD_CAM   = 8'h0F;
   localparam logic [7:0] CMD_IR    = 8'h13;
   localparam logic [7:0] CMD_IDLE  = 8'h10;
   localparam logic [7:0] CMD_LEFT  = 8'h14;
   localparam logic [7:0] CMD_RIGHT = 8'h18;
   localparam logic [7:0] CMD_FWD   = 8'h1B;
   localparam logic [7:0] CMD_FWD1  = 8'h1F;
   localparam logic [7:0] CMD_STOP  = 8'h0C;

   localparam logic [2:0] CAMDIR_LEFT   = 3'b001;
   localparam logic [2:0] CAMDIR_RIGHT  = 3'b010;
   localparam logic [2:0] CAMDIR_CENTRE = 3'b011;

endpackage

// File: rtl/drive_mode_ctrl_if.sv
// Signal bundle between the vehicle sensors/remote and the drive mode controller.
interface drive_mode_ctrl_if #(
   parameter int CMD_W = 8,
   parameter int SPD_W = 2
);
   // ir_valid is a one-cycle strobe without back-pressure: ir_cmd is consumed
   // on every clk_50 edge where ir_valid is high and ignored otherwise.
   logic             ir_valid;
   logic [CMD_W-1:0] ir_cmd;
   logic [2:0]       cam_dir;
   logic             orange_detected;
   logic [SPD_W-1:0] speed_req;
   logic             estop;

   logic [1:0]       mode;
   logic [1:0]       cam_state;
   logic [1:0]       drive_dir;
   logic [SPD_W-1:0] drive_speed;
   logic             mode_change;
   logic             wd_trip;
   logic             search_expired;

   modport master (
      output ir_valid, ir_cmd, cam_dir, orange_detected, speed_req, estop,
      input  mode, cam_state, drive_dir, drive_speed, mode_change, wd_trip, search_expired
   );

   modport slave (
      input  ir_valid, ir_cmd, cam_dir, orange_detected, speed_req, estop,
      output mode, cam_state, drive_dir, drive_speed, mode_change, wd_trip, search_expired
   );
endinterface

// File: rtl/speed_ramp.sv
// Registered speed level: climbs one level per RAMP_CYCLES, drops instantly.
module speed_ramp #(
   parameter int SPD_W       = 2,
   parameter int RAMP_CYCLES = 1_000_000
) (
   input  logic             clk_50,
   input  logic             reset,
   input  logic             i_clear,
   input  logic [SPD_W-1:0] i_target,
   output logic [SPD_W-1:0] o_speed
);
   localparam int RW = $clog2(RAMP_CYCLES + 1);

   logic [SPD_W-1:0] r_speed;
   logic [RW-1:0]    r_cnt;

   always_ff @(posedge clk_50) begin
      if (reset || i_clear) begin
         r_speed <= '0;
         r_cnt   <= '0;
      end else if (i_target < r_speed) begin
         r_speed <= i_target;
         r_cnt   <= '0;
      end else if (i_target > r_speed) begin
         if (r_cnt >= RW'(RAMP_CYCLES - 1)) begin
            r_speed <= r_speed + 1'b1;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign o_speed = r_speed;
endmodule

// File: rtl/drive_mode_ctrl.sv
// Drive mode controller: IR/camera mode FSMs, IR watchdog, search timeout and
// a registered direction/speed output with gap-on-reversal and speed ramp.
module drive_mode_ctrl
   import drive_pkg::*;
#(
   parameter int CMD_W          = 8,
   parameter int SPEED_LEVELS   = 3,
   parameter int IR_TIMEOUT     = 25_000_000,
   parameter int LOST_HOLD      = 5_000_000,
   parameter int SEARCH_TIMEOUT = 500_000_000,
   parameter int RAMP_CYCLES    = 1_000_000
) (
   input logic              clk_50,
   input logic              reset,
   drive_mode_ctrl_if.slave bus
);
   localparam int SPD_W = $clog2(SPEED_LEVELS + 1);
   localparam int SW    = $clog2(SEARCH_TIMEOUT + 1);
   localparam int LW    = $clog2(LOST_HOLD + 1);
   localparam int WW    = $clog2(IR_TIMEOUT + 1);

   mode_e            r_mode, w_mode_nx;
   cam_e             r_cam, w_cam_nx;
   logic [SW-1:0]    r_search_cnt, w_search_cnt_nx;
   logic [LW-1:0]    r_lost_cnt, w_lost_cnt_nx;
   logic [WW-1:0]    r_wd_cnt, w_wd_cnt_nx;
   dir_e             r_ir_dir, w_ir_dir_nx;
   logic             r_ir_slow, w_ir_slow_nx;
   logic             w_wd_trip_nx;
   logic             w_cmd_cam, w_cmd_ir, w_cmd_idle, w_mode_cmd, w_expire;
   dir_e             r_dir, w_dir_nx, w_tgt_dir;
   logic [SPD_W-1:0] w_tgt_spd, w_spd_req_sat, w_speed;
   logic             w_gap, w_ramp_clr;
   logic             r_mode_change, r_search_expired, r_wd_trip;

   assign w_cmd_cam  = bus.ir_valid && (bus.ir_cmd == CMD_W'(CMD_CAM));
   assign w_cmd_ir   = bus.ir_valid && (bus.ir_cmd == CMD_W'(CMD_IR));
   assign w_cmd_idle = bus.ir_valid && (bus.ir_cmd == CMD_W'(CMD_IDLE));
   assign w_mode_cmd = w_cmd_cam || w_cmd_ir || w_cmd_idle;
   // A mode command in the same cycle wins over the search timeout.
   assign w_expire   = (r_cam == CAM_SEARCH) && (r_search_cnt == SW'(SEARCH_TIMEOUT - 1)) && !w_mode_cmd;

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_mode       <= MODE_IDLE;
         r_cam        <= CAM_PAUSE;
         r_search_cnt <= '0;
         r_lost_cnt   <= '0;
         r_wd_cnt     <= '0;
         r_ir_dir     <= DIR_STOP;
         r_ir_slow    <= 1'b0;
      end else begin
         r_mode       <= w_mode_nx;
         r_cam        <= w_cam_nx;
         r_search_cnt <= w_search_cnt_nx;
         r_lost_cnt   <= w_lost_cnt_nx;
         r_wd_cnt     <= w_wd_cnt_nx;
         r_ir_dir     <= w_ir_dir_nx;
         r_ir_slow    <= w_ir_slow_nx;
      end
   end

   always_comb begin
      w_mode_nx = r_mode;
      if (w_cmd_cam)       w_mode_nx = MODE_CAM;
      else if (w_cmd_ir)   w_mode_nx = MODE_IR;
      else if (w_cmd_idle) w_mode_nx = MODE_IDLE;
      else if (w_expire)   w_mode_nx = MODE_IDLE;

      w_cam_nx      = r_cam;
      w_lost_cnt_nx = '0;
      if (w_mode_nx != MODE_CAM) begin
         w_cam_nx = CAM_PAUSE;
      end else if (r_mode != MODE_CAM) begin
         w_cam_nx = CAM_SEARCH;
      end else begin
         case (r_cam)
            CAM_SEARCH: if (bus.orange_detected) w_cam_nx = CAM_FOLLOW;
            CAM_FOLLOW: if (!bus.orange_detected) begin
               w_cam_nx      = CAM_LOST;
               w_lost_cnt_nx = LW'(1);
            end
            CAM_LOST: begin
               if (bus.orange_detected)                   w_cam_nx = CAM_FOLLOW;
               else if (r_lost_cnt >= LW'(LOST_HOLD - 1)) w_cam_nx = CAM_SEARCH;
               else                                       w_lost_cnt_nx = r_lost_cnt + 1'b1;
            end
            default: w_cam_nx = CAM_SEARCH;
         endcase
      end

      w_search_cnt_nx = '0;
      if (r_cam == CAM_SEARCH && w_cam_nx == CAM_SEARCH)
         w_search_cnt_nx = (r_search_cnt == SW'(SEARCH_TIMEOUT - 1)) ? r_search_cnt : r_search_cnt + 1'b1;

      w_ir_dir_nx  = DIR_STOP;
      w_ir_slow_nx = 1'b0;
      w_wd_cnt_nx  = '0;
      if (w_mode_nx == MODE_IR && r_mode == MODE_IR) begin
         w_ir_dir_nx  = r_ir_dir;
         w_ir_slow_nx = r_ir_slow;
         if (bus.ir_valid) begin
            if (bus.ir_cmd == CMD_W'(CMD_LEFT))       begin w_ir_dir_nx = DIR_LEFT;  w_ir_slow_nx = 1'b0; end
            else if (bus.ir_cmd == CMD_W'(CMD_RIGHT)) begin w_ir_dir_nx = DIR_RIGHT; w_ir_slow_nx = 1'b0; end
            else if (bus.ir_cmd == CMD_W'(CMD_FWD))   begin w_ir_dir_nx = DIR_FWD;   w_ir_slow_nx = 1'b0; end
            else if (bus.ir_cmd == CMD_W'(CMD_FWD1))  begin w_ir_dir_nx = DIR_FWD;   w_ir_slow_nx = 1'b1; end
            else if (bus.ir_cmd == CMD_W'(CMD_STOP))  begin w_ir_dir_nx = DIR_STOP;  w_ir_slow_nx = 1'b0; end
         end else begin
            w_wd_cnt_nx = (r_wd_cnt == WW'(IR_TIMEOUT)) ? r_wd_cnt : r_wd_cnt + 1'b1;
         end
      end
      // Saturated silence counter doubles as the sticky trip flag.
      w_wd_trip_nx = (w_wd_cnt_nx == WW'(IR_TIMEOUT));
   end

   always_comb begin
      w_tgt_dir = DIR_STOP;
      if (w_mode_nx == MODE_CAM) begin
         if (bus.cam_dir == CAMDIR_LEFT)       w_tgt_dir = DIR_LEFT;
         else if (bus.cam_dir == CAMDIR_RIGHT) w_tgt_dir = DIR_RIGHT;
         else if (bus.cam_dir == CAMDIR_CENTRE && w_cam_nx == CAM_FOLLOW) w_tgt_dir = DIR_FWD;
      end else if (w_mode_nx == MODE_IR && !w_wd_trip_nx) begin
         w_tgt_dir = w_ir_dir_nx;
      end

      w_spd_req_sat = (bus.speed_req > SPD_W'(SPEED_LEVELS)) ? SPD_W'(SPEED_LEVELS) : bus.speed_req;
      case (w_tgt_dir)
         DIR_STOP: w_tgt_spd = '0;
         DIR_FWD:  w_tgt_spd = (w_mode_nx == MODE_IR && w_ir_slow_nx) ? SPD_W'(1) : w_spd_req_sat;
         default:  w_tgt_spd = SPD_W'(1);
      endcase

      // Switching between two moving directions passes through one STOP/0 cycle.
      w_gap      = (r_dir != DIR_STOP) && (w_tgt_dir != DIR_STOP) && (w_tgt_dir != r_dir);
      w_ramp_clr = bus.estop || w_gap || (w_tgt_dir == DIR_STOP);
      w_dir_nx   = w_ramp_clr ? DIR_STOP : w_tgt_dir;
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_dir            <= DIR_STOP;
         r_mode_change    <= 1'b0;
         r_search_expired <= 1'b0;
         r_wd_trip        <= 1'b0;
      end else begin
         r_dir            <= w_dir_nx;
         r_mode_change    <= (w_mode_nx != r_mode) || (w_cam_nx != r_cam);
         r_search_expired <= w_expire;
         r_wd_trip        <= w_wd_trip_nx;
      end
   end

   speed_ramp #(
      .SPD_W       (SPD_W),
      .RAMP_CYCLES (RAMP_CYCLES)
   ) u_speed_ramp (
      .clk_50   (clk_50),
      .reset    (reset),
      .i_clear  (w_ramp_clr),
      .i_target (w_tgt_spd),
      .o_speed  (w_speed)
   );

   assign bus.mode           = r_mode;
   assign bus.cam_state      = r_cam;
   assign bus.drive_dir      = r_dir;
   assign bus.drive_speed    = w_speed;
   assign bus.mode_change    = r_mode_change;
   assign bus.wd_trip        = r_wd_trip;
   assign bus.search_expired = r_search_expired;
endmodule
